// File: rtl/lsu_pkg.sv
// Load/store unit shared types.
// MEM-stage FSM states, funct3 size codes, writeback code.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } mem_size_e;

  // Loads arrive fully extended, so writeback is always a word write.
  localparam logic [2:0] WRITE_WORD = 3'b001;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store unit.
// Store: enables, replication, legality. Load: lane select, extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        st_we,
  input  logic [2:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        st_misalign,
  input  logic [2:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] lane;

  // Request side: byte enables, replicated data, alignment/legality.
  always_comb begin
    st_be       = 4'b1111;
    st_wdata    = st_data;
    st_misalign = 1'b0;
    unique case (1'b1)
      (st_size == SZ_B): begin
        if (st_we) begin
          st_be    = 4'b0001 << st_off;
          st_wdata = {4{st_data[7:0]}};
        end
      end
      (st_size == SZ_H): begin
        st_misalign = st_off[0];
        if (st_we) begin
          st_be    = 4'b0011 << st_off;
          st_wdata = {2{st_data[15:0]}};
        end
      end
      (st_size == SZ_W): begin
        st_misalign = |st_off;
      end
      (st_size == SZ_BU): begin
        st_misalign = st_we;
      end
      (st_size == SZ_HU): begin
        st_misalign = st_we | st_off[0];
      end
      default: begin
        st_misalign = 1'b1;
      end
    endcase
  end

  assign lane = ld_rdata >> {ld_off, 3'b000};

  // Response side: pick the addressed lane and extend to a full word.
  always_comb begin
    ld_data = lane;
    unique case (1'b1)
      (ld_size == SZ_B):  ld_data = {{24{lane[7]}}, lane[7:0]};
      (ld_size == SZ_H):  ld_data = {{16{lane[15]}}, lane[15:0]};
      (ld_size == SZ_BU): ld_data = {24'd0, lane[7:0]};
      (ld_size == SZ_HU): ld_data = {16'd0, lane[15:0]};
      default:            ld_data = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit.
// Request latch, req/ack bus FSM with timeout, response pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic [2:0]            req_size_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  stall_o,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  misalign_o,
  output logic                  bus_err_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_t            state;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [2:0]            lat_size;
  logic                  lat_we;
  logic [3:0]            lat_be;
  logic [DATA_WIDTH-1:0] lat_wdata;

  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic                  st_mis;
  logic [DATA_WIDTH-1:0] ld_data;

  lsu_align u_align (
    .st_we       (req_we_i),
    .st_size     (req_size_i),
    .st_off      (req_addr_i[1:0]),
    .st_data     (req_wdata_i),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .st_misalign (st_mis),
    .ld_size     (lat_size),
    .ld_off      (lat_addr[1:0]),
    .ld_rdata    (mem_rdata_i),
    .ld_data     (ld_data)
  );

  assign stall_o = ((state == IDLE) & req_valid_i)
                 | (state == BUS);

  assign mem_we_o    = lat_we;
  assign mem_be_o    = lat_be;
  assign mem_wdata_o = lat_wdata;
  assign mem_addr_o  = {lat_addr[ADDR_WIDTH-1:2], 2'b00};

  // Transaction FSM: latch request, run bus with timeout, pulse response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_addr    <= '0;
      lat_size    <= '0;
      lat_we      <= 1'b0;
      lat_be      <= '0;
      lat_wdata   <= '0;
      mem_req_o   <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            lat_addr    <= req_addr_i;
            lat_size    <= req_size_i;
            lat_we      <= req_we_i;
            lat_be      <= st_be;
            lat_wdata   <= st_wdata;
            rsp_rdata_o <= '0;
            if (st_mis) begin
              state       <= DONE;
              rsp_valid_o <= 1'b1;
              misalign_o  <= 1'b1;
            end else begin
              state     <= BUS;
              mem_req_o <= 1'b1;
              cnt       <= '0;
            end
          end
        end
        BUS: begin
          if (mem_ack_i) begin
            state       <= DONE;
            mem_req_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            if (!lat_we) begin
              rsp_rdata_o <= ld_data;
            end
          end else if (cnt == CNT_LAST) begin
            state       <= DONE;
            mem_req_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            bus_err_o   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state       <= IDLE;
          rsp_rdata_o <= '0;
        end
        default: begin
          state     <= IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit.
// Random loads/stores against a plain-arithmetic reference model.
module tb_load_store_unit;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_size = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misalign;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  load_store_unit #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_we_i    (req_we),
    .req_size_i  (req_size),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .stall_o     (stall),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .misalign_o  (misalign),
    .bus_err_o   (bus_err),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_be_o    (mem_be),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        mis;
    logic        err;
    int          req_cyc;
    int          lat;
    int          issue;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   req_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  function automatic exp_t model(logic we, logic [2:0] sz,
                                 logic [31:0] a, logic [31:0] d,
                                 logic [31:0] rd, int dly);
    exp_t        e;
    int          off;
    logic [31:0] lane;
    logic [31:0] v;
    bit          legal;
    off = int'(a % 4);
    if (we) legal = (sz == 0 || sz == 1 || sz == 2);
    else    legal = (sz == 0 || sz == 1 || sz == 2 || sz == 4 || sz == 5);
    if ((sz == 1 || sz == 5) && (a % 2 != 0)) legal = 0;
    if (sz == 2 && off != 0) legal = 0;
    e.addr = a - 32'(off);
    e.we   = we;
    e.mis  = !legal;
    e.err  = legal && dly >= T;
    if (!we)          e.be = 4'hF;
    else if (sz == 0) e.be = 4'(1 << off);
    else if (sz == 1) e.be = 4'(3 << off);
    else              e.be = 4'hF;
    if (sz == 0)      e.wdata = 32'(d[7:0]) * 32'h01010101;
    else if (sz == 1) e.wdata = 32'(d[15:0]) * 32'h00010001;
    else              e.wdata = d;
    lane = rd >> (8 * off);
    case (sz)
      3'd0: begin
        v = lane & 32'hFF;
        if (v >= 128) v = v - 256;
      end
      3'd1: begin
        v = lane & 32'hFFFF;
        if (v >= 32768) v = v - 65536;
      end
      3'd4: v = lane & 32'hFF;
      3'd5: v = lane & 32'hFFFF;
      default: v = lane;
    endcase
    e.rdata   = (!legal || we || e.err) ? 32'd0 : v;
    e.req_cyc = !legal ? 0 : (dly >= T ? T : dly + 1);
    e.lat     = !legal ? 1 : (dly >= T ? T + 1 : dly + 2);
    e.issue   = 0;
    return e;
  endfunction

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the
  // next IDLE cycle so requests can go back to back.
  task automatic txn(logic we, logic [2:0] sz, logic [31:0] a,
                     logic [31:0] d, logic [31:0] rd, int dly);
    exp_t e;
    e = model(we, sz, a, d, rd, dly);
    e.issue = cyc;
    q.push_back(e);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    if (e.mis) begin
      @(posedge clk); #1;
      return;
    end
    for (int i = 0; i < dly && i < T; i++) begin
      mem_rdata = $urandom;
      @(posedge clk); #1;
    end
    mem_ack   = 1'b1;
    mem_rdata = (dly < T) ? rd : $urandom;
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (dly < T) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: stall shape, bus fields, and response against the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      req_cnt = 0;
    end else begin
      if (q.size() > 0) begin
        check("stall", stall,
              ((cyc - q[0].issue) < q[0].lat) ? 1 : 0);
        if (mem_req) begin
          req_cnt++;
          check("bus_addr", mem_addr, q[0].addr);
          check("bus_be", mem_be, q[0].be);
          check("bus_we", mem_we, q[0].we);
          if (q[0].we) check("bus_wdata", mem_wdata, q[0].wdata);
        end
        if (rsp_valid) begin
          exp_t f;
          f = q.pop_front();
          check("rsp_rdata", rsp_rdata, f.rdata);
          check("rsp_misalign", misalign, f.mis);
          check("rsp_bus_err", bus_err, f.err);
          check("req_cycles", req_cnt, f.req_cyc);
          check("latency", cyc - f.issue, f.lat);
          req_cnt = 0;
        end else begin
          check("err_no_rsp", {misalign, bus_err}, 0);
        end
      end else begin
        check("idle_rsp", rsp_valid, 0);
        check("idle_req", mem_req, 0);
        check("idle_stall", stall, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        we;
    logic [2:0]  sz;
    logic [31:0] a;
    int          dly;
    exp_t        e;

    #12;
    check("reset_req", mem_req, 0);
    check("reset_rsp", rsp_valid, 0);
    check("reset_rdata", rsp_rdata, 0);
    check("reset_err", {misalign, bus_err}, 0);
    check("reset_stall", stall, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    txn(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    txn(0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0);
    txn(0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 2);
    txn(1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 1);
    txn(0, 3'b010, 32'h101, 32'h0, 32'h12345678, 0);
    txn(0, 3'b010, 32'h200, 32'h0, 32'hCAFEF00D, T + 3);
    txn(0, 3'b010, 32'h204, 32'h0, 32'h0BADBEEF, T - 1);
    txn(1, 3'b100, 32'h300, 32'h11223344, 32'h0, 0);
    txn(0, 3'b111, 32'h300, 32'h0, 32'h0, 0);

    for (int n = 0; n < 80; n++) begin
      we  = 1'($urandom_range(0, 1));
      sz  = 3'($urandom_range(0, 7));
      a   = $urandom;
      dly = ($urandom_range(0, 7) == 0) ? $urandom_range(T - 1, T + 4)
                                        : $urandom_range(0, 4);
      txn(we, sz, a, $urandom, $urandom, dly);
    end

    e = model(0, 3'b010, 32'h300, 32'h0, 32'h0, T + 5);
    e.issue = cyc;
    q.push_back(e);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 3'b010;
    req_addr  = 32'h300;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("pre_rst_req", mem_req, 1);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("rst_req_drop", mem_req, 0);
    check("rst_no_rsp", rsp_valid, 0);
    check("rst_stall", stall, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    txn(0, 3'b101, 32'h0, $urandom, 32'h1234F00D, 1);
    txn(0, 3'b001, 32'h2, 32'h0, 32'h8001F00D, 0);

    repeat (2) begin
      @(posedge clk); #1;
    end
    check("drain", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
